// File: rtl/audio_tone_gen_pkg.sv
// Shared types and helpers for the multi-channel audio test-tone generator.
package audio_tone_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW      = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_SILENT   = 2'd3
    } wave_mode_t;

    // 2^(bits-1): zero level of an offset-binary sample of the given width.
    function automatic logic [31:0] midscale(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/audio_tone_gen_if.sv
// Control and sample bus between the tone generator and its consumer (hdmi audio port).
interface audio_tone_gen_if import audio_tone_pkg::*; #(
    parameter int BIT_WIDTH   = 16,
    parameter int CHANNELS    = 2,
    parameter int PHASE_WIDTH = 24
);
    logic                                  enable;
    logic                                  sync;
    wave_mode_t [CHANNELS-1:0]             mode;
    logic [CHANNELS-1:0][PHASE_WIDTH-1:0]  freq_word;
    logic [CHANNELS-1:0][BIT_WIDTH-1:0]    level;

    // sample_valid is a one-cycle strobe with no ready: the consumer must take
    // sample_word in the cycle it is high; sample_word then holds until the next strobe.
    logic [CHANNELS-1:0][BIT_WIDTH-1:0]    sample_word;
    logic                                  sample_valid;
    logic [CHANNELS-1:0]                   pwm_out;

    modport master (
        output enable, sync, mode, freq_word, level,
        input  sample_word, sample_valid, pwm_out
    );

    modport slave (
        input  enable, sync, mode, freq_word, level,
        output sample_word, sample_valid, pwm_out
    );
endinterface

// File: rtl/audio_tone_gen_tone_channel.sv
// One tone channel: phase accumulator, waveform shaper, level scaler and optional
// sigma-delta PWM (present only when AUDIO_TONE_GEN_PWM_EN is defined).
module tone_channel import audio_tone_pkg::*; #(
    parameter int BIT_WIDTH   = 16,
    parameter int PHASE_WIDTH = 24
) (
    input  logic                   clk_audio,
    input  logic                   RESETn,
    input  logic                   strobe,
    input  logic                   strobe_d,
    input  logic                   sync,
    input  logic                   enable,
    input  wave_mode_t             mode,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic [BIT_WIDTH-1:0]   level,
    output logic [BIT_WIDTH-1:0]   sample_word,
    output logic                   pwm_out
);
    localparam int B = BIT_WIDTH;
    localparam int P = PHASE_WIDTH;
    localparam logic [31:0]  MID32 = midscale(B);
    localparam logic [B-1:0] MID   = MID32[B-1:0];

    logic [P-1:0]          phase;
    logic [B-1:0]          w;
    logic signed [B-1:0]   s_q;
    logic [B-1:0]          level_q;
    logic                  en_q;
    logic signed [2*B:0]   s_ext;
    logic signed [2*B:0]   l_ext;
    logic signed [2*B:0]   prod;
    logic [B-1:0]          y;

    always_comb begin
        w = MID;
        case (mode)
            WAVE_SAW:      w = phase[P-1 -: B];
            WAVE_SQUARE:   w = {B{phase[P-1]}};
            WAVE_TRIANGLE: w = phase[P-2 -: B] ^ {B{phase[P-1]}};
            default:       w = MID;
        endcase
    end

    // Stage 1: shape from the pre-increment phase, capture level/enable, advance phase.
    always_ff @(posedge clk_audio or negedge RESETn) begin
        if (!RESETn) begin
            phase   <= '0;
            s_q     <= '0;
            level_q <= '0;
            en_q    <= 1'b0;
        end else if (strobe) begin
            s_q     <= w - MID;
            level_q <= level;
            en_q    <= enable;
            if (sync) begin
                phase <= '0;
            end else if (enable) begin
                phase <= phase + freq_word;
            end
        end
    end

    // Full-precision signed product; the arithmetic shift floors and always fits B bits.
    assign s_ext = (2*B+1)'(s_q);
    assign l_ext = (2*B+1)'({1'b0, level_q});
    assign prod  = s_ext * l_ext;
    assign y     = B'(prod >>> B);

    always_ff @(posedge clk_audio or negedge RESETn) begin
        if (!RESETn) begin
            sample_word <= '0;
        end else if (strobe_d) begin
            sample_word <= en_q ? y : '0;
        end
    end

`ifdef AUDIO_TONE_GEN_PWM_EN
    logic [B-1:0] u;
    logic [B:0]   acc;

    // First-order sigma-delta on the offset-binary sample; carry out is the bitstream.
    assign u = {~sample_word[B-1], sample_word[B-2:0]};

    always_ff @(posedge clk_audio or negedge RESETn) begin
        if (!RESETn) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[B-1:0]} + {1'b0, u};
        end
    end

    assign pwm_out = acc[B];
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: rtl/audio_tone_gen.sv
// Multi-channel audio test-tone generator in the clk_audio domain.
// Optional per-channel sigma-delta PWM outputs are enabled by AUDIO_TONE_GEN_PWM_EN.
module audio_tone_gen import audio_tone_pkg::*; #(
    parameter int BIT_WIDTH   = 16,
    parameter int CHANNELS    = 2,
    parameter int PHASE_WIDTH = 24,
    parameter int CLK_DIV     = 1
) (
    input  logic             clk_audio,
    input  logic             RESETn,
    audio_tone_gen_if.slave  bus
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]                    div_cnt;
    logic                                strobe;
    logic                                strobe_d;
    logic                                sample_valid_q;
    logic                                sync_pend;
    logic                                sync_eff;
    logic [CHANNELS-1:0][BIT_WIDTH-1:0]  words;
    logic [CHANNELS-1:0]                 pwm;

    assign strobe = (div_cnt == DIV_LAST);

    // A sync pulse seen between strobes is remembered so it still zeroes the next strobe.
    assign sync_eff = bus.sync | sync_pend;

    always_ff @(posedge clk_audio or negedge RESETn) begin
        if (!RESETn) begin
            div_cnt        <= '0;
            strobe_d       <= 1'b0;
            sample_valid_q <= 1'b0;
            sync_pend      <= 1'b0;
        end else begin
            div_cnt        <= strobe ? '0 : div_cnt + 1'b1;
            strobe_d       <= strobe;
            sample_valid_q <= strobe_d;
            sync_pend      <= strobe ? 1'b0 : (sync_pend | bus.sync);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        tone_channel #(
            .BIT_WIDTH   (BIT_WIDTH),
            .PHASE_WIDTH (PHASE_WIDTH)
        ) u_ch (
            .clk_audio   (clk_audio),
            .RESETn      (RESETn),
            .strobe      (strobe),
            .strobe_d    (strobe_d),
            .sync        (sync_eff),
            .enable      (bus.enable),
            .mode        (bus.mode[i]),
            .freq_word   (bus.freq_word[i]),
            .level       (bus.level[i]),
            .sample_word (words[i]),
            .pwm_out     (pwm[i])
        );
    end

    assign bus.sample_word  = words;
    assign bus.sample_valid = sample_valid_q;
    assign bus.pwm_out      = pwm;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Bench for audio_tone_gen: directed vector table, hand sequences and a randomized
// run against a per-strobe arithmetic reference model.
module tb_audio_tone_gen;
    import audio_tone_pkg::*;

    localparam int B   = 16;
    localparam int P   = 24;
    localparam int CH  = 2;
    localparam int DIV = 4;

    // ---------------- clock / reset ----------------
    logic clk_audio = 1'b0;
    logic RESETn;
    always #5 clk_audio = ~clk_audio;

    audio_tone_gen_if #(.BIT_WIDTH(B), .CHANNELS(CH), .PHASE_WIDTH(P)) bus ();
    audio_tone_gen_if #(.BIT_WIDTH(B), .CHANNELS(CH), .PHASE_WIDTH(P)) bus1 ();

    audio_tone_gen #(.BIT_WIDTH(B), .CHANNELS(CH), .PHASE_WIDTH(P), .CLK_DIV(DIV)) dut (
        .clk_audio (clk_audio),
        .RESETn    (RESETn),
        .bus       (bus)
    );

    audio_tone_gen #(.BIT_WIDTH(B), .CHANNELS(CH), .PHASE_WIDTH(P), .CLK_DIV(1)) dut1 (
        .clk_audio (clk_audio),
        .RESETn    (RESETn),
        .bus       (bus1)
    );

    // ---------------- scoreboard state ----------------
    int              n_vec;
    int              n_fail;
    int              cyc;
    int              m_phase [CH];
    int              m_acc   [CH];
    logic [B-1:0]    m_word  [CH];
    logic            m_valid;
    bit              sync_seen;
    logic [CH*B-1:0] exp_q [$];
    int              due_q [$];

    typedef struct {
        wave_mode_t   mode;
        logic [P-1:0] freq;
        logic [B-1:0] lvl;
        logic [B-1:0] exp0;
        logic [B-1:0] exp1;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Unsigned waveform value of a phase, from the waveform definitions.
    function automatic int shape(input wave_mode_t m, input int ph);
        int half;
        int t;
        half = 1 << (P - 1);
        t    = (ph % half) / (1 << (P - 1 - B));
        case (m)
            WAVE_SAW:      return ph / (1 << (P - B));
            WAVE_SQUARE:   return (ph >= half) ? (1 << B) - 1 : 0;
            WAVE_TRIANGLE: return (ph >= half) ? ((1 << B) - 1 - t) : t;
            default:       return 1 << (B - 1);
        endcase
    endfunction

    function automatic logic [B-1:0] ref_sample(input wave_mode_t m, input int ph,
                                                input int lvl, input bit en);
        longint s;
        longint p;
        longint q;
        if (!en) return '0;
        s = longint'(shape(m, ph)) - (longint'(1) << (B - 1));
        p = s * longint'(lvl);
        q = p / (longint'(1) << B);
        if (p < 0 && (p % (longint'(1) << B)) != 0) q = q - 1;
        return q[B-1:0];
    endfunction

    task automatic model_reset();
        cyc       = 0;
        sync_seen = 0;
        m_valid   = 0;
        exp_q.delete();
        due_q.delete();
        for (int i = 0; i < CH; i++) begin
            m_phase[i] = 0;
            m_acc[i]   = 0;
            m_word[i]  = '0;
        end
    endtask

    // One clock: fold this cycle's inputs into the model, advance, compare at the negedge.
    task automatic tick();
        logic [CH*B-1:0] v;
        sync_seen = sync_seen | bus.sync;
        if ((cyc % DIV) == DIV - 1) begin
            for (int i = 0; i < CH; i++) begin
                v[i*B +: B] = ref_sample(bus.mode[i], m_phase[i], int'(bus.level[i]), bus.enable);
                if (sync_seen)       m_phase[i] = 0;
                else if (bus.enable) m_phase[i] = (m_phase[i] + int'(bus.freq_word[i])) % (1 << P);
            end
            exp_q.push_back(v);
            due_q.push_back(cyc + 2);
            sync_seen = 0;
        end
        @(posedge clk_audio);
        @(negedge clk_audio);
        cyc++;
        for (int i = 0; i < CH; i++)
            m_acc[i] = (m_acc[i] % (1 << B)) + int'(m_word[i] ^ 16'h8000);
        m_valid = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            v = exp_q.pop_front();
            void'(due_q.pop_front());
            m_valid = 1;
            for (int i = 0; i < CH; i++) m_word[i] = v[i*B +: B];
        end
        check("sample_valid", 32'(bus.sample_valid), 32'(m_valid));
        for (int i = 0; i < CH; i++) begin
            check("sample_word", 32'(bus.sample_word[i]), 32'(m_word[i]));
`ifdef AUDIO_TONE_GEN_PWM_EN
            check("pwm_out", 32'(bus.pwm_out[i]), (m_acc[i] >= (1 << B)) ? 32'd1 : 32'd0);
`else
            check("pwm_out", 32'(bus.pwm_out[i]), 32'd0);
`endif
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk_audio);
        #2 RESETn = 1'b0;
        #1;
        check("rst_sample_word", 32'(bus.sample_word), 32'd0);
        check("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_pwm_out", 32'(bus.pwm_out), 32'd0);
        check("rst_div1_valid", 32'(bus1.sample_valid), 32'd0);
        model_reset();
        @(negedge clk_audio);
        @(negedge clk_audio);
        #1 RESETn = 1'b1;
    endtask

    task automatic set_ch(input int i, input wave_mode_t m, input logic [P-1:0] f,
                          input logic [B-1:0] l);
        bus.mode[i]      = m;
        bus.freq_word[i] = f;
        bus.level[i]     = l;
    endtask

    task automatic rand_ch(input int i);
        set_ch(i, wave_mode_t'(2'($urandom_range(0, 3))),
               ($urandom_range(0, 3) == 0) ? P'($urandom_range(0, 15)) : P'($urandom()),
               B'($urandom()));
    endtask

    task automatic wait_sample(output logic [B-1:0] w);
        w = '0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (bus.sample_valid === 1'b1) begin
                w = bus.sample_word[0];
                return;
            end
        end
        check("sample_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [B-1:0]        a;
        logic [B-1:0]        b;
        logic [B-1:0]        c;
        logic signed [B-1:0] tri_s [17];
        logic [B-1:0]        saw_s [257];
        int                  ones;
        int                  repeats;
        int                  first_cyc;
        int                  best;
        logic                prev;

        n_vec  = 0;
        n_fail = 0;
        RESETn = 1'b0;
        bus.enable = 1'b1;
        bus.sync   = 1'b0;
        for (int i = 0; i < CH; i++) set_ch(i, WAVE_SAW, 24'h010000, 16'hFFFF);
        bus1.enable = 1'b1;
        bus1.sync   = 1'b0;
        for (int i = 0; i < CH; i++) begin
            bus1.mode[i]      = WAVE_SAW;
            bus1.freq_word[i] = 24'h010000;
            bus1.level[i]     = 16'hFFFF;
        end
        model_reset();

        tbl[0] = '{WAVE_SAW,      24'h010000, 16'hFFFF, 16'h8000, 16'h8100};
        tbl[1] = '{WAVE_SQUARE,   24'h800000, 16'h8000, 16'hC000, 16'h3FFF};
        tbl[2] = '{WAVE_SQUARE,   24'h800000, 16'h0000, 16'h0000, 16'h0000};
        tbl[3] = '{WAVE_TRIANGLE, 24'h100000, 16'hFFFF, 16'h8000, 16'hA000};
        tbl[4] = '{WAVE_SILENT,   24'h123456, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[5] = '{WAVE_SAW,      24'h000000, 16'hFFFF, 16'h8000, 16'h8000};
        tbl[6] = '{WAVE_SAW,      24'h800000, 16'h8000, 16'hC000, 16'h0000};
        tbl[7] = '{WAVE_TRIANGLE, 24'h800000, 16'hFFFF, 16'h8000, 16'h7FFE};

        // Directed vectors: first two samples after reset on channel 0.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            set_ch(0, tbl[r].mode, tbl[r].freq, tbl[r].lvl);
            rand_ch(1);
            bus.enable = 1'b1;
            wait_sample(a);
            first_cyc = cyc;
            wait_sample(b);
            check("tbl_sample0", 32'(a), 32'(tbl[r].exp0));
            check("tbl_sample1", 32'(b), 32'(tbl[r].exp1));
            if (r == 0) begin
                check("first_sample_cycle", 32'(first_cyc), 32'd5);
                check("second_sample_cycle", 32'(cyc), 32'd9);
            end
        end

        // CLK_DIV=1 instance: valid continuously from cycle 2, one ramp step per cycle.
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            check("div1_valid", 32'(bus1.sample_valid), (k >= 2) ? 32'd1 : 32'd0);
            check("div1_word", 32'(bus1.sample_word[0]),
                  (k >= 2) ? 32'h8000 + 32'(k - 2) * 32'h100 : 32'd0);
        end

        // Saw period of 256 samples.
        do_reset();
        set_ch(0, WAVE_SAW, 24'h010000, 16'hFFFF);
        set_ch(1, WAVE_SQUARE, 24'h020000, 16'h4000);
        for (int k = 0; k < 257; k++) wait_sample(saw_s[k]);
        check("saw_step", 32'(saw_s[1]), 32'h8100);
        check("saw_period", 32'(saw_s[256]), 32'(saw_s[0]));

        // Triangle: 16-sample period, peak at sample 8, symmetric within rounding.
        do_reset();
        set_ch(0, WAVE_TRIANGLE, 24'h100000, 16'hFFFF);
        for (int k = 0; k < 17; k++) wait_sample(tri_s[k]);
        best = 0;
        for (int k = 1; k < 16; k++) if (tri_s[k] > tri_s[best]) best = k;
        check("tri_peak_index", 32'(best), 32'd8);
        check("tri_period", 32'(tri_s[16]), 32'(tri_s[0]));
        for (int j = 1; j < 8; j++) begin
            int d;
            d = int'(tri_s[8 - j]) - int'(tri_s[8 + j]);
            check("tri_symmetry", (d >= -2 && d <= 2) ? 32'd1 : 32'd0, 32'd1);
        end

        // Sync pulsed between strobes: the sample after the next one restarts at 0x8000.
        do_reset();
        set_ch(0, WAVE_SAW, 24'h010000, 16'hFFFF);
        for (int k = 0; k < 5; k++) wait_sample(a);
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        wait_sample(a);
        wait_sample(b);
        wait_sample(c);
        check("sync_old_phase", 32'(a), 32'h8500);
        check("sync_restart", 32'(b), 32'h8000);
        check("sync_next", 32'(c), 32'h8100);

        // Enable low mutes and holds phase; re-enable resumes from the held phase.
        do_reset();
        set_ch(0, WAVE_SAW, 24'h010000, 16'hFFFF);
        for (int k = 0; k < 3; k++) wait_sample(a);
        bus.enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_sample(b);
            check("mute_sample", 32'(b), 32'd0);
        end
        bus.enable = 1'b1;
        wait_sample(c);
        check("resume_sample", 32'(c), 32'(a) + 32'h100);

        // PWM on a constant midscale channel.
        do_reset();
        set_ch(0, WAVE_SILENT, 24'h000000, 16'hFFFF);
        set_ch(1, WAVE_SILENT, 24'h000000, 16'hFFFF);
        ones    = 0;
        repeats = 0;
        prev    = bus.pwm_out[0];
        for (int k = 0; k < 1024; k++) begin
            tick();
            if (bus.pwm_out[0] === 1'b1) ones++;
            if (k > 0 && bus.pwm_out[0] === prev) repeats++;
            prev = bus.pwm_out[0];
        end
`ifdef AUDIO_TONE_GEN_PWM_EN
        check("pwm_ones_1024", 32'(ones), 32'd512);
        check("pwm_alternate", 32'(repeats), 32'd0);
`else
        check("pwm_ones_1024", 32'(ones), 32'd0);
`endif

        // Randomized run with inputs changing between strobes and a mid-run reset.
        do_reset();
        rand_ch(0);
        rand_ch(1);
        bus.enable = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            if (k == 1500) begin
                do_reset();
            end
            if ($urandom_range(0, 5) == 0) rand_ch(int'($urandom_range(0, CH - 1)));
            bus.enable = ($urandom_range(0, 15) != 0);
            bus.sync   = ($urandom_range(0, 40) == 0);
            tick();
        end
        bus.sync = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
